// File: rtl/dac_serial_tx.sv
// Serial DAC transmitter: frames each accepted sample as {CTRL, sample, zero pad}
// and shifts it out MSB first on an SPI-style link (sclk idles low, data valid on
// the rising edge), then pulses o_frame_done once the frame and its hold time end.
module dac_serial_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CTRL    = 4'b0000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sample,
  input  logic             i_sample_valid,
  output logic             o_sample_ready,
  output logic             o_sclk,
  output logic             o_sdata,
  output logic             o_cs_n,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StShift,
    StHold
  } state_e;

  state_e      r_state, w_state;
  logic [15:0] r_shreg, w_shreg;
  logic [7:0]  r_div, w_div;
  logic [3:0]  r_bit, w_bit;
  logic        r_half, w_half;
  logic        r_sclk, w_sclk;
  logic        r_sdata, w_sdata;
  logic        r_cs_n, w_cs_n;
  logic        r_busy, w_busy;
  logic        r_ready, w_ready;
  logic        r_done, w_done;
  logic        w_div_last;
  logic [15:0] w_frame;

  // Left-justify {CTRL, sample} in 16 bits so the pad falls out as zeros.
  assign w_frame    = 16'({CTRL, i_sample}) << (12 - WIDTH);
  assign w_div_last = (r_div == DivLast);

  // State and registered outputs; reset aborts any frame immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_half  <= 1'b0;
      r_sclk  <= 1'b0;
      r_sdata <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shreg <= w_shreg;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_half  <= w_half;
      r_sclk  <= w_sclk;
      r_sdata <= w_sdata;
      r_cs_n  <= w_cs_n;
      r_busy  <= w_busy;
      r_ready <= w_ready;
      r_done  <= w_done;
    end
  end

  // Next-state and next-output logic; outputs are computed one edge ahead.
  always_comb begin
    w_state = r_state;
    w_shreg = r_shreg;
    w_div   = w_div_last ? 8'd0 : r_div + 8'd1;
    w_bit   = r_bit;
    w_half  = r_half;
    w_sclk  = r_sclk;
    w_sdata = r_sdata;
    w_cs_n  = r_cs_n;
    w_busy  = r_busy;
    w_ready = r_ready;
    w_done  = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_div = 8'd0;
        if (i_sample_valid && r_ready) begin
          w_state = StSetup;
          w_shreg = w_frame;
          w_sdata = w_frame[15];
          w_cs_n  = 1'b0;
          w_sclk  = 1'b0;
          w_busy  = 1'b1;
          w_ready = 1'b0;
        end
      end
      StSetup: begin
        if (w_div_last) begin
          w_state = StShift;
          w_div   = 8'd0;
          w_bit   = 4'd15;
          w_half  = 1'b0;
        end
      end
      StShift: begin
        if (w_div_last) begin
          w_div = 8'd0;
          if (!r_half) begin
            // Rising sclk: the DAC samples the bit already on sdata.
            w_sclk = 1'b1;
            w_half = 1'b1;
          end else if (r_bit == 4'd0) begin
            w_state = StHold;
            w_sclk  = 1'b0;
            w_half  = 1'b0;
            w_cs_n  = 1'b1;
            w_sdata = 1'b0;
          end else begin
            // Falling sclk: present the next bit.
            w_sclk  = 1'b0;
            w_half  = 1'b0;
            w_shreg = {r_shreg[14:0], 1'b0};
            w_sdata = r_shreg[14];
            w_bit   = r_bit - 4'd1;
          end
        end
      end
      StHold: begin
        if (w_div_last) begin
          w_state = StIdle;
          w_div   = 8'd0;
          w_done  = 1'b1;
          w_ready = 1'b1;
          w_busy  = 1'b0;
        end
      end
      default: begin
        w_state = StIdle;
      end
    endcase
  end

  assign o_sample_ready = r_ready;
  assign o_sclk         = r_sclk;
  assign o_sdata        = r_sdata;
  assign o_cs_n         = r_cs_n;
  assign o_busy         = r_busy;
  assign o_frame_done   = r_done;

endmodule

// File: tb/tb_dac_serial_tx.sv
// Directed bench for dac_serial_tx: one instance at CLK_DIV=4 and one at CLK_DIV=1,
// with a small counter/lookup model feeding the second for the index-chain check.
module tb_dac_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // CLK_DIV=4 instance
  logic       rst4_n, vld4, rdy4, sclk4, sd4, cs4, busy4, done4;
  logic [7:0] smp4;
  // CLK_DIV=1 instance
  logic       rst1_n, vld1, rdy1, sclk1, sd1, cs1, busy1, done1;
  logic [7:0] direct1, smp1;
  logic       chain = 1'b0;
  logic [7:0] idx   = 8'hFE;

  // Stand-in for the Functions lookup indexed by the Counter.
  function automatic logic [7:0] fn(input logic [7:0] i);
    return i ^ 8'h3C;
  endfunction

  assign smp1 = chain ? fn(idx) : direct1;

  dac_serial_tx #(.WIDTH(8), .CLK_DIV(4), .CTRL(4'b0000)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst4_n), .i_sample(smp4), .i_sample_valid(vld4),
    .o_sample_ready(rdy4), .o_sclk(sclk4), .o_sdata(sd4), .o_cs_n(cs4),
    .o_busy(busy4), .o_frame_done(done4)
  );

  dac_serial_tx #(.WIDTH(8), .CLK_DIV(1), .CTRL(4'b0000)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n), .i_sample(smp1), .i_sample_valid(vld1),
    .o_sample_ready(rdy1), .o_sclk(sclk1), .o_sdata(sd1), .o_cs_n(cs1),
    .o_busy(busy1), .o_frame_done(done1)
  );

  // Link monitors: capture bits on sclk rise, time accept/done, measure sclk high time.
  int          cyc = 0;
  logic [15:0] cap4 = '0, frame4 = '0, cap1 = '0, frame1 = '0;
  int          nb4 = 0, nbf4 = 0, hi4 = 0, hibad4 = 0, tacc4 = 0, tdone4 = 0, ndone4 = 0;
  int          nb1 = 0, nbf1 = 0, hi1 = 0, hibad1 = 0, tacc1 = 0, tdone1 = 0, ndone1 = 0;
  logic        cs4_p = 1'b1, sclk4_p = 1'b0, busy4_p = 1'b0;
  logic        cs1_p = 1'b1, sclk1_p = 1'b0, busy1_p = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!cs4 && cs4_p) begin cap4 = '0; nb4 = 0; end
    if (sclk4 && !sclk4_p) begin cap4 = {cap4[14:0], sd4}; nb4++; hi4 = 0; end
    if (sclk4) hi4++;
    if (!sclk4 && sclk4_p && hi4 != 4) hibad4++;
    if (busy4 && !busy4_p) tacc4 = cyc;
    if (done4) begin tdone4 = cyc; ndone4++; frame4 = cap4; nbf4 = nb4; end
    cs4_p = cs4; sclk4_p = sclk4; busy4_p = busy4;

    if (!cs1 && cs1_p) begin cap1 = '0; nb1 = 0; end
    if (sclk1 && !sclk1_p) begin cap1 = {cap1[14:0], sd1}; nb1++; hi1 = 0; end
    if (sclk1) hi1++;
    if (!sclk1 && sclk1_p && hi1 != 1) hibad1++;
    if (busy1 && !busy1_p) tacc1 = cyc;
    if (done1) begin
      tdone1 = cyc; ndone1++; frame1 = cap1; nbf1 = nb1;
      if (chain) idx = idx + 8'd1;
    end
    cs1_p = cs1; sclk1_p = sclk1; busy1_p = busy1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done4(input int target, input int budget);
    for (int i = 0; i < budget && ndone4 < target; i++) tick();
    chk("done_cnt4", ndone4, target);
  endtask

  task automatic wait_done1(input int target, input int budget);
    for (int i = 0; i < budget && ndone1 < target; i++) tick();
    chk("done_cnt1", ndone1, target);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ta1, nd;
    logic act;

    // Reset state and idle quietness
    rst4_n = 1'b0; rst1_n = 1'b0;
    vld4 = 1'b0; vld1 = 1'b0; smp4 = '0; direct1 = '0;
    repeat (5) tick();
    chk("rst_ready", rdy4, 1'b1);
    chk("rst_cs_n", cs4, 1'b1);
    chk("rst_sclk", sclk4, 1'b0);
    chk("rst_sdata", sd4, 1'b0);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    rst4_n = 1'b1; rst1_n = 1'b1;
    act = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      act = act | !cs4 | sclk4 | busy4 | done4 | !rdy4 | !cs1 | sclk1 | busy1;
    end
    chk("idle_quiet", act, 1'b0);

    // Single frame 0xA5 at CLK_DIV=4
    smp4 = 8'hA5; vld4 = 1'b1;
    tick();
    vld4 = 1'b0; smp4 = 8'h00;
    chk("t2_busy", busy4, 1'b1);
    chk("t2_ready", rdy4, 1'b0);
    wait_done4(1, 400);
    chk("t2_frame", frame4, 16'h0A50);
    chk("t2_nbits", nbf4, 16);
    chk("t2_latency", tdone4 - tacc4, 136);
    chk("t2_sclk_high", hibad4, 0);
    tick();
    chk("t2_ready_back", rdy4, 1'b1);

    // Held valid, sample changes mid-frame, back-to-back accept
    smp4 = 8'h3C; vld4 = 1'b1;
    tick();
    ta1 = tacc4;
    tick();
    smp4 = 8'hC3;
    wait_done4(2, 400);
    chk("t3_frame1", frame4, 16'h03C0);
    for (int i = 0; i < 5 && tacc4 == ta1; i++) tick();
    vld4 = 1'b0;
    chk("t3_gap", tacc4 - tdone4, 1);
    chk("t3_period", tacc4 - ta1, 137);
    wait_done4(3, 400);
    chk("t3_frame2", frame4, 16'h0C30);
    chk("t3_sclk_high", hibad4, 0);

    // Reset during SHIFT at bit 7
    tick();
    smp4 = 8'h5A; vld4 = 1'b1;
    tick();
    vld4 = 1'b0;
    nd = ndone4;
    for (int i = 0; i < 200 && nb4 < 9; i++) tick();
    chk("t5_at_bit7", nb4, 9);
    rst4_n = 1'b0;
    #1;
    chk("t5_cs_n", cs4, 1'b1);
    chk("t5_sclk", sclk4, 1'b0);
    chk("t5_busy", busy4, 1'b0);
    chk("t5_ready", rdy4, 1'b1);
    repeat (3) tick();
    chk("t5_no_done", ndone4, nd);
    rst4_n = 1'b1; smp4 = 8'h96; vld4 = 1'b1;
    tick();
    vld4 = 1'b0;
    chk("t5_accept_first", busy4, 1'b1);
    wait_done4(nd + 1, 400);
    chk("t5_frame", frame4, 16'h0960);
    chk("t5_nbits", nbf4, 16);
    chk("t5_latency", tdone4 - tacc4, 136);

    // CLK_DIV=1, sample 0xFF
    direct1 = 8'hFF; vld1 = 1'b1;
    tick();
    vld1 = 1'b0;
    wait_done1(1, 100);
    chk("t6_frame", frame1, 16'h0FF0);
    chk("t6_latency", tdone1 - tacc1, 34);
    chk("t6_sclk_high", hibad1, 0);

    // Counter/lookup chain, index wrap FF -> 00
    tick();
    chain = 1'b1; vld1 = 1'b1;
    wait_done1(2, 100);
    chk("t4_frame_fe", frame1, 16'h0C20);
    chk("t4_idx_ff", idx, 8'hFF);
    wait_done1(3, 100);
    chk("t4_frame_ff", frame1, 16'h0C30);
    chk("t4_idx_00", idx, 8'h00);
    wait_done1(4, 100);
    chk("t4_frame_00", frame1, 16'h03C0);
    chk("t4_idx_01", idx, 8'h01);
    vld1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
